// File: rtl/master_txn_queue.sv
// Transaction issue queue feeding a PCI bus-master Controller.
// Buffers pending transactions, sequences bursts and retires entries from snooped bus phases.
module master_txn_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_add,
    input  logic        push,
    input  logic [1:0]  push_addr,
    input  logic        push_rd_wr,
    input  logic [3:0]  push_be,
    input  logic [31:0] push_data,
    input  logic [3:0]  push_len,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    input  logic        gnt,
    input  logic        frame,
    input  logic        irdy,
    input  logic        trdy,
    input  logic [31:0] d,
    output logic [1:0]  address,
    output logic [3:0]  BE,
    output logic        force_req,
    output logic        rd_wr,
    output logic [31:0] data,
    output logic        burst,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [1:0]    addr_mem_r [DEPTH];
    logic          rdwr_mem_r [DEPTH];
    logic [3:0]    be_mem_r   [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [3:0]    len_mem_r  [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [3:0]    remaining_r;
    logic [TW-1:0] tcnt_r;
    logic          overflow_r;
    logic [31:0]   rdata_r;
    logic          rdata_valid_r;
    logic          done_r;

    logic          full_s;
    logic          empty_s;
    logic          phase_s;
    logic          retire_s;
    logic          push_ok_s;
    logic          timeout_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign phase_s   = (state_r == S_DATA) && !irdy && !trdy;
    assign retire_s  = phase_s && (remaining_r == 4'd0);
    // A full queue can still take a push in the cycle its head retires.
    assign push_ok_s = push && (!full_s || retire_s);
    assign timeout_s = (tcnt_r == TW'(TIMEOUT - 1));

    assign full        = full_s;
    assign empty       = empty_s;
    assign overflow    = overflow_r;
    assign address     = empty_s ? 2'd0  : addr_mem_r[rd_ptr_r];
    assign BE          = empty_s ? 4'd0  : be_mem_r[rd_ptr_r];
    assign rd_wr       = empty_s ? 1'b0  : rdwr_mem_r[rd_ptr_r];
    assign data        = empty_s ? 32'd0 : data_mem_r[rd_ptr_r];
    assign force_req   = (state_r == S_REQ);
    assign burst       = ((state_r == S_WAIT) || (state_r == S_ADDR) || (state_r == S_DATA))
                         && (remaining_r != 4'd0);
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign done        = done_r;

    // Next-state logic for the request/transfer sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ:  state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (!gnt && !frame) begin
                    state_nxt_s = S_ADDR;
                end else if (timeout_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_ADDR: state_nxt_s = S_DATA;
            S_DATA: begin
                if (retire_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Sequencer state, phase counting, grant timeout and bus-facing strobes.
    always_ff @(posedge clk) begin
        if (reset_add) begin
            state_r       <= S_IDLE;
            remaining_r   <= 4'd0;
            tcnt_r        <= {TW{1'b0}};
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rdata_valid_r <= phase_s && rdwr_mem_r[rd_ptr_r];
            done_r        <= retire_s;
            if (phase_s && rdwr_mem_r[rd_ptr_r]) begin
                rdata_r <= d;
            end
            if (state_r == S_REQ) begin
                remaining_r <= len_mem_r[rd_ptr_r];
            end else if (phase_s && (remaining_r != 4'd0)) begin
                remaining_r <= remaining_r - 4'd1;
            end
            if (state_r == S_REQ) begin
                tcnt_r <= {TW{1'b0}};
            end else if ((state_r == S_WAIT) && !timeout_s) begin
                tcnt_r <= tcnt_r + TW'(1);
            end
        end
    end

    // Circular-buffer pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset_add) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, retire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            addr_mem_r[wr_ptr_r] <= push_addr;
            rdwr_mem_r[wr_ptr_r] <= push_rd_wr;
            be_mem_r[wr_ptr_r]   <= push_be;
            data_mem_r[wr_ptr_r] <= push_data;
            len_mem_r[wr_ptr_r]  <= push_len;
        end
    end

endmodule

// File: tb/tb_master_txn_queue.sv
// Self-checking bench for master_txn_queue: directed bus handshakes plus a
// read-data scoreboard filled at stimulus time and drained on rdata_valid.
module tb_master_txn_queue;

    logic        clk;
    logic        reset_add;
    logic        push;
    logic [1:0]  push_addr;
    logic        push_rd_wr;
    logic [3:0]  push_be;
    logic [31:0] push_data;
    logic [3:0]  push_len;
    logic        full, empty, overflow;
    logic        gnt, frame, irdy, trdy;
    logic [31:0] d;
    logic [1:0]  address;
    logic [3:0]  BE;
    logic        force_req, rd_wr, burst, rdata_valid, done;
    logic [31:0] data, rdata;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];

    master_txn_queue #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_add(reset_add),
        .push(push), .push_addr(push_addr), .push_rd_wr(push_rd_wr),
        .push_be(push_be), .push_data(push_data), .push_len(push_len),
        .full(full), .empty(empty), .overflow(overflow),
        .gnt(gnt), .frame(frame), .irdy(irdy), .trdy(trdy), .d(d),
        .address(address), .BE(BE), .force_req(force_req), .rd_wr(rd_wr),
        .data(data), .burst(burst), .rdata(rdata), .rdata_valid(rdata_valid),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [1:0] a, input logic rw, input logic [3:0] be,
                           input logic [31:0] dat, input logic [3:0] len);
        push_addr = a; push_rd_wr = rw; push_be = be; push_data = dat; push_len = len;
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (force_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", {31'd0, force_req}, 32'd1);
    endtask

    // Serves the head as a write; optionally pushes (preloaded fields) on the final phase.
    task automatic serve(input logic [1:0] exp_addr, input int phases, input bit push_last);
        wait_req();
        check("head_addr", {30'd0, address}, {30'd0, exp_addr});
        tick();
        gnt = 1'b0; frame = 1'b0;
        tick();
        gnt = 1'b1; frame = 1'b1;
        tick();
        for (int i = 0; i < phases; i++) begin
            irdy = 1'b0; trdy = 1'b0;
            if (push_last && i == phases - 1) push = 1'b1;
            tick();
            push = 1'b0;
        end
        irdy = 1'b1; trdy = 1'b1;
        check("serve_done", {31'd0, done}, 32'd1);
    endtask

    // Scoreboard drain and retirement counting, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rdata_unexpected", 32'd1, 32'd0);
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        push = 1'b0; push_addr = 2'd0; push_rd_wr = 1'b0; push_be = 4'd0;
        push_data = 32'd0; push_len = 4'd0;
        gnt = 1'b1; frame = 1'b1; irdy = 1'b1; trdy = 1'b1; d = 32'd0;
        reset_add = 1'b1;
        tick(); tick();
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_force_req", {31'd0, force_req}, 32'd0);
        check("rst_burst", {31'd0, burst}, 32'd0);
        check("rst_address", {30'd0, address}, 32'd0);
        check("rst_be", {28'd0, BE}, 32'd0);
        check("rst_rd_wr", {31'd0, rd_wr}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset_add = 1'b0;

        // Single write
        do_push(2'd1, 1'b0, 4'hF, 32'hAAAA_AAAA, 4'd0);
        check("sw_empty", {31'd0, empty}, 32'd0);
        check("sw_address", {30'd0, address}, 32'd1);
        check("sw_be", {28'd0, BE}, 32'hF);
        check("sw_data", data, 32'hAAAA_AAAA);
        check("sw_req_early", {31'd0, force_req}, 32'd0);
        tick();
        check("sw_req_pulse", {31'd0, force_req}, 32'd1);
        check("sw_burst_req", {31'd0, burst}, 32'd0);
        tick();
        check("sw_req_end", {31'd0, force_req}, 32'd0);
        tick();
        gnt = 1'b0; frame = 1'b0;
        tick();
        gnt = 1'b1; frame = 1'b1;
        check("sw_burst_addr", {31'd0, burst}, 32'd0);
        tick();
        check("sw_burst_data", {31'd0, burst}, 32'd0);
        irdy = 1'b0; trdy = 1'b0;
        tick();
        irdy = 1'b1; trdy = 1'b1;
        check("sw_done", {31'd0, done}, 32'd1);
        check("sw_empty_after", {31'd0, empty}, 32'd1);
        check("sw_no_rvalid", {31'd0, rdata_valid}, 32'd0);
        tick();
        check("sw_done_once", {31'd0, done}, 32'd0);

        // Burst read of four phases
        do_push(2'd0, 1'b1, 4'h3, 32'd0, 4'd3);
        tick();
        check("br_req", {31'd0, force_req}, 32'd1);
        tick();
        check("br_burst_wait", {31'd0, burst}, 32'd1);
        gnt = 1'b0; frame = 1'b0;
        tick();
        gnt = 1'b1; frame = 1'b1;
        check("br_burst_addr", {31'd0, burst}, 32'd1);
        tick();
        check("br_rd_wr", {31'd0, rd_wr}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            d = 32'(i); irdy = 1'b0; trdy = 1'b0;
            exp_q.push_back(32'(i));
            tick();
            check("br_burst", {31'd0, burst}, (i < 3) ? 32'd1 : 32'd0);
            check("br_done", {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
        end
        irdy = 1'b1; trdy = 1'b1;
        tick();
        check("br_done_once", {31'd0, done}, 32'd0);
        check("br_empty", {31'd0, empty}, 32'd1);

        // Fill, push-on-retire while full, overflow, then drain in order
        reset_add = 1'b1; tick(); reset_add = 1'b0;
        for (int i = 0; i < 4; i++) do_push(2'(i), 1'b0, 4'hF, 32'(i), 4'd0);
        check("ov_full4", {31'd0, full}, 32'd1);
        check("ov_not_yet", {31'd0, overflow}, 32'd0);
        push_addr = 2'd2; push_rd_wr = 1'b0; push_be = 4'h1; push_data = 32'h55; push_len = 4'd0;
        serve(2'd0, 1, 1'b1);
        check("ov_full_retire_push", {31'd0, full}, 32'd1);
        check("ov_retire_push_ok", {31'd0, overflow}, 32'd0);
        do_push(2'd3, 1'b0, 4'hF, 32'h99, 4'd0);
        check("ov_sticky", {31'd0, overflow}, 32'd1);
        check("ov_still_full", {31'd0, full}, 32'd1);
        serve(2'd1, 1, 1'b0);
        serve(2'd2, 1, 1'b0);
        serve(2'd3, 1, 1'b0);
        serve(2'd2, 1, 1'b0);
        check("ov_drained", {31'd0, empty}, 32'd1);
        check("ov_sticky_hold", {31'd0, overflow}, 32'd1);

        // Grant timeout retry period
        reset_add = 1'b1; tick(); reset_add = 1'b0;
        check("to_ov_clear", {31'd0, overflow}, 32'd0);
        do_push(2'd1, 1'b0, 4'hF, 32'h1, 4'd0);
        wait_req();
        for (int r = 0; r < 2; r++) begin
            tick();
            n = 1;
            while (force_req !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            check("to_period", 32'(n), 32'd17);
        end

        // Reset in the middle of a burst
        reset_add = 1'b1; tick(); reset_add = 1'b0;
        do_push(2'd2, 1'b1, 4'hF, 32'd0, 4'd2);
        wait_req();
        tick();
        gnt = 1'b0; frame = 1'b0;
        tick();
        gnt = 1'b1; frame = 1'b1;
        tick();
        check("mr_burst_before", {31'd0, burst}, 32'd1);
        reset_add = 1'b1;
        tick();
        reset_add = 1'b0;
        check("mr_burst", {31'd0, burst}, 32'd0);
        check("mr_empty", {31'd0, empty}, 32'd1);
        check("mr_done", {31'd0, done}, 32'd0);
        tick(); tick();
        check("mr_idle", {31'd0, force_req}, 32'd0);
        check("mr_no_done", {31'd0, done}, 32'd0);

        check("done_total", 32'(done_cnt), 32'd7);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
